pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 The block SHALL have parameter AW, default 5, register-address width.
REQ-002 The block SHALL have parameter BR_STAGE, default 1, branch resolve stage (1 = ID, 2 = EXE).
REQ-003 The block SHALL have parameter MEM_TO, default 0, data-memory timeout in cycles (0 = no timeout).
REQ-004 The block SHALL have parameter CW, default 16, stall-counter width.
REQ-005 The block SHALL have ports clk in 1 (main clock) and rst_n in 1 (asynchronous, active-low reset).
REQ-006 The block SHALL have ports id_rs, id_rt in AW (ID source addresses) and id_rs_use, id_rt_use in 1 (source actually read).
REQ-007 The block SHALL have ports exe_rs, exe_rt in AW (EXE operand addresses).
REQ-008 The block SHALL have ports exe_wdst, mem_wdst, wb_wdst in AW and exe_wen, mem_wen, wb_wen in 1 (destinations and write enables).
REQ-009 The block SHALL have ports exe_is_load, mem_is_load in 1 (load in stage).
REQ-010 The block SHALL have ports id_is_branch, branch_taken in 1 (branch in ID; taken, resolved in BR_STAGE).
REQ-011 The block SHALL have ports dmem_req, dmem_ack in 1 (MEM-stage access request and completion).
REQ-012 The block SHALL have output ports if_en, id_en, exe_en, mem_en, wb_en, each 1 bit (stage register enables).
REQ-013 The block SHALL have output ports id_flush, exe_flush, each 1 bit (synchronous bubble into the stage register).
REQ-014 The block SHALL have output ports fwd_a, fwd_b, each 2 bits (0 = regfile, 1 = MEM result, 2 = WB result).
REQ-015 The block SHALL have output ports mem_err (1 bit, timeout sticky) and stall_cnt (CW bits, stall cycles).

Function
REQ-016 Forwarding SHALL be combinational: fwd_a = 1 if mem_wen && mem_wdst != 0 && mem_wdst == exe_rs && !mem_is_load.
REQ-017 Otherwise fwd_a SHALL be 2 if wb_wen && wb_wdst != 0 && wb_wdst == exe_rs, else 0; fwd_b is identical using exe_rt.
REQ-018 Load-use SHALL be detected when exe_is_load && exe_wen && exe_wdst != 0 && exe_wdst matches a used ID source.
REQ-019 On load-use, if_en = id_en = 0 and exe_flush = 1 for one cycle.
REQ-020 When BR_STAGE = 1 and id_is_branch, the block SHALL also stall (as REQ-019) on an EXE destination match with exe_wen, or a MEM destination match with mem_is_load.
REQ-021 When BR_STAGE = 1 and branch_taken is asserted without a stall, id_flush SHALL be 1.
REQ-022 When BR_STAGE = 2 and branch_taken is asserted, id_flush = exe_flush = 1, and branch_taken SHALL override the load-use stall.
REQ-023 The FSM SHALL have states RUN, MEM_WAIT and ERR.
REQ-024 In RUN with dmem_req && !dmem_ack the FSM SHALL go to MEM_WAIT; dmem_req && dmem_ack in the same cycle SHALL stay in RUN with no stall.
REQ-025 In MEM_WAIT all five enables SHALL be 0 and flushes SHALL be 0; dmem_ack SHALL return to RUN, and enables rise in the same cycle as ack.
REQ-026 The wait timer SHALL count cycles in MEM_WAIT; when MEM_TO != 0 and the timer reaches MEM_TO without ack, the FSM SHALL go to ERR.
REQ-027 In ERR all enables SHALL be 0 and mem_err SHALL be 1 until reset.
REQ-028 Priority SHALL be ERR > MEM_WAIT/memory stall > branch flush (EXE mode) > load-use/branch-operand stall > branch flush (ID mode).
REQ-029 A branch or load hazard raised during MEM_WAIT SHALL be evaluated after return to RUN, because stage contents are frozen.
REQ-030 stall_cnt SHALL increment every cycle in which if_en = 0 and the FSM is not in ERR, saturating at all-ones.

Reset
REQ-031 rst_n low SHALL asynchronously set: FSM to RUN, timer 0, stall_cnt 0, mem_err 0, enables 0, flushes 0, fwd 0.
REQ-032 On the first cycle after rst_n goes high, enables SHALL be 1.
REQ-033 Reset mid-MEM_WAIT SHALL abandon the wait, and a stale dmem_ack after reset SHALL be ignored.

Structure
REQ-034 The fwd-select encodings and the FSM state encoding SHALL live in the shared define header alongside the existing core defines.
REQ-035 One sub-module, fwd_sel (a single-operand forwarding comparator), SHALL be instantiated twice, for A and B.

Verification
REQ-036 exe_rs = 3, mem_wdst = 3, mem_wen = 1, wb_wdst = 3, wb_wen = 1 -> fwd_a = 1; with mem_wen = 0 -> fwd_a = 2; with exe_rs = 0 -> fwd_a = 0.
REQ-037 exe_is_load = 1, exe_wdst = 5, id_rt = 5, id_rt_use = 1 -> one cycle with if_en = id_en = 0, exe_flush = 1, stall_cnt += 1.
REQ-038 BR_STAGE = 2, branch_taken with a simultaneous load-use -> id_flush = exe_flush = 1, if_en = 1.
REQ-039 dmem_req, ack after 4 cycles -> 4 cycles with all enables 0, then RUN; ack in the request cycle -> 0 stall cycles.
REQ-040 MEM_TO = 8, no ack -> ERR after 8 cycles, mem_err = 1 held; rst_n low -> mem_err = 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard unit: FSM states, forwarding selects,
// and the stage-control bundle driven toward the pipeline registers.
package pipe_hazard_unit_pkg;

    localparam int unsigned FWD_W = 2;

    // Operand source select for the EXE-stage ALU inputs
    typedef enum logic [FWD_W-1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // Memory-handshake controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hz_state_t;

    // Per-cycle stage register enables and bubble injections
    typedef struct packed {
        logic if_en;
        logic id_en;
        logic exe_en;
        logic mem_en;
        logic wb_en;
        logic id_flush;
        logic exe_flush;
    } stage_ctrl_t;

    // Whole pipeline frozen, nothing flushed
    localparam stage_ctrl_t CTRL_HOLD = '{
        if_en: 1'b0, id_en: 1'b0, exe_en: 1'b0, mem_en: 1'b0, wb_en: 1'b0,
        id_flush: 1'b0, exe_flush: 1'b0
    };

    // Pipeline flowing freely
    localparam stage_ctrl_t CTRL_RUN = '{
        if_en: 1'b1, id_en: 1'b1, exe_en: 1'b1, mem_en: 1'b1, wb_en: 1'b1,
        id_flush: 1'b0, exe_flush: 1'b0
    };

endpackage

// File: rtl/pipe_hazard_unit_fwd_sel.sv
// fwd_sel: single-operand forwarding comparator. MEM result wins over WB result;
// loads in MEM cannot forward (data not yet back), register 0 never forwards.
module pipe_hazard_unit_fwd_sel
    import pipe_hazard_unit_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_mem_wdst,
    input  logic          i_mem_wen,
    input  logic          i_mem_is_load,
    input  logic [AW-1:0] i_wb_wdst,
    input  logic          i_wb_wen,
    output fwd_sel_t      o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_wen && (i_mem_wdst != '0) && (i_mem_wdst == i_src) && !i_mem_is_load;
    assign w_wb_hit  = i_wb_wen && (i_wb_wdst != '0) && (i_wb_wdst == i_src);

    // Priority select: youngest producer first
    always_comb begin
        o_sel = FWD_RF;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use and branch-operand
// stalls, branch flushes, and a data-memory wait/timeout controller.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int unsigned AW       = 5,
    parameter int unsigned BR_STAGE = 1,
    parameter int unsigned MEM_TO   = 0,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_id_rs,
    input  logic [AW-1:0] i_id_rt,
    input  logic          i_id_rs_use,
    input  logic          i_id_rt_use,
    input  logic [AW-1:0] i_exe_rs,
    input  logic [AW-1:0] i_exe_rt,
    input  logic [AW-1:0] i_exe_wdst,
    input  logic [AW-1:0] i_mem_wdst,
    input  logic [AW-1:0] i_wb_wdst,
    input  logic          i_exe_wen,
    input  logic          i_mem_wen,
    input  logic          i_wb_wen,
    input  logic          i_exe_is_load,
    input  logic          i_mem_is_load,
    input  logic          i_id_is_branch,
    input  logic          i_branch_taken,
    input  logic          i_dmem_req,
    input  logic          i_dmem_ack,
    output logic          o_if_en,
    output logic          o_id_en,
    output logic          o_exe_en,
    output logic          o_mem_en,
    output logic          o_wb_en,
    output logic          o_id_flush,
    output logic          o_exe_flush,
    output logic [1:0]    o_fwd_a,
    output logic [1:0]    o_fwd_b,
    output logic          o_mem_err,
    output logic [CW-1:0] o_stall_cnt
);

    // Timer wide enough to hold MEM_TO; one bit when the timeout is disabled
    localparam int unsigned TW = (MEM_TO > 0) ? $clog2(MEM_TO + 1) : 1;

    hz_state_t     r_state;
    logic [TW-1:0] r_timer;
    logic [CW-1:0] r_stall_cnt;
    logic          r_mem_err;
    logic          r_live;

    fwd_sel_t      w_fwd_a;
    fwd_sel_t      w_fwd_b;
    logic          w_exe_hit;
    logic          w_mem_hit;
    logic          w_ld_use;
    logic          w_br_haz;
    logic          w_mem_stall;
    stage_ctrl_t   w_ctrl;

    pipe_hazard_unit_fwd_sel #(.AW(AW)) u_fwd_sel_a (
        .i_src         (i_exe_rs),
        .i_mem_wdst    (i_mem_wdst),
        .i_mem_wen     (i_mem_wen),
        .i_mem_is_load (i_mem_is_load),
        .i_wb_wdst     (i_wb_wdst),
        .i_wb_wen      (i_wb_wen),
        .o_sel         (w_fwd_a)
    );

    pipe_hazard_unit_fwd_sel #(.AW(AW)) u_fwd_sel_b (
        .i_src         (i_exe_rt),
        .i_mem_wdst    (i_mem_wdst),
        .i_mem_wen     (i_mem_wen),
        .i_mem_is_load (i_mem_is_load),
        .i_wb_wdst     (i_wb_wdst),
        .i_wb_wen      (i_wb_wen),
        .o_sel         (w_fwd_b)
    );

    // A nonzero destination in EXE/MEM that the ID instruction actually reads
    assign w_exe_hit = (i_exe_wdst != '0) &&
                       ((i_id_rs_use && (i_id_rs == i_exe_wdst)) ||
                        (i_id_rt_use && (i_id_rt == i_exe_wdst)));
    assign w_mem_hit = (i_mem_wdst != '0) &&
                       ((i_id_rs_use && (i_id_rs == i_mem_wdst)) ||
                        (i_id_rt_use && (i_id_rt == i_mem_wdst)));

    assign w_ld_use = i_exe_is_load && i_exe_wen && w_exe_hit;

    // ID-resolved branches compare operands in ID, so they also wait on ALU results in EXE
    // and on loads still in MEM
    assign w_br_haz = (BR_STAGE == 1) && i_id_is_branch &&
                      ((i_exe_wen && w_exe_hit) || (i_mem_is_load && i_mem_wen && w_mem_hit));

    // Memory not done this cycle: either still waiting, or a fresh request without ack
    assign w_mem_stall = (r_state == ST_MEM_WAIT) ? !i_dmem_ack
                                                  : (i_dmem_req && !i_dmem_ack);

    // Stage-control priority: error/reset > memory stall > EXE branch flush > hazard stall > ID branch flush
    always_comb begin
        w_ctrl = CTRL_HOLD;
        if (!r_live || (r_state == ST_ERR) || w_mem_stall) begin
            w_ctrl = CTRL_HOLD;
        end else if ((BR_STAGE == 2) && i_branch_taken) begin
            w_ctrl           = CTRL_RUN;
            w_ctrl.id_flush  = 1'b1;
            w_ctrl.exe_flush = 1'b1;
        end else if (w_ld_use || w_br_haz) begin
            w_ctrl           = CTRL_RUN;
            w_ctrl.if_en     = 1'b0;
            w_ctrl.id_en     = 1'b0;
            w_ctrl.exe_flush = 1'b1;
        end else if ((BR_STAGE == 1) && i_branch_taken) begin
            w_ctrl          = CTRL_RUN;
            w_ctrl.id_flush = 1'b1;
        end else begin
            w_ctrl = CTRL_RUN;
        end
    end

    // Memory-wait FSM, timeout timer, sticky error and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_timer     <= '0;
            r_stall_cnt <= '0;
            r_mem_err   <= 1'b0;
            r_live      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_RUN: begin
                    if (i_dmem_req && !i_dmem_ack) begin
                        r_state <= ST_MEM_WAIT;
                        r_timer <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_dmem_ack) begin
                        r_state <= ST_RUN;
                        r_timer <= '0;
                    end else if (MEM_TO != 0) begin
                        if (r_timer == TW'(MEM_TO - 1)) begin
                            r_state   <= ST_ERR;
                            r_mem_err <= 1'b1;
                        end
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_ERR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
            if (r_live && (r_state != ST_ERR) && !w_ctrl.if_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
        end
    end

    assign o_if_en     = w_ctrl.if_en;
    assign o_id_en     = w_ctrl.id_en;
    assign o_exe_en    = w_ctrl.exe_en;
    assign o_mem_en    = w_ctrl.mem_en;
    assign o_wb_en     = w_ctrl.wb_en;
    assign o_id_flush  = w_ctrl.id_flush;
    assign o_exe_flush = w_ctrl.exe_flush;
    assign o_fwd_a     = r_live ? w_fwd_a : FWD_RF;
    assign o_fwd_b     = r_live ? w_fwd_b : FWD_RF;
    assign o_mem_err   = r_mem_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: two instances (ID-resolved branches with an 8-cycle
// memory timeout, EXE-resolved branches with no timeout) share one stimulus stream.
module tb_pipe_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, exe_rs, exe_rt, exe_wdst, mem_wdst, wb_wdst;
    logic       id_rs_use, id_rt_use, exe_wen, mem_wen, wb_wen;
    logic       exe_is_load, mem_is_load, id_is_branch, branch_taken;
    logic       dmem_req, dmem_ack;

    logic        if_en[2], id_en[2], exe_en[2], mem_en[2], wb_en[2];
    logic        id_flush[2], exe_flush[2], mem_err[2];
    logic [1:0]  fwd_a[2], fwd_b[2];
    logic [15:0] stall_cnt[2];

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = ID branches / timeout 8, index 1 = EXE branches / no timeout
    int br_of[2]  = '{1, 2};
    int mto_of[2] = '{8, 0};
    bit m_live[2];
    bit m_busy[2];
    bit m_err[2];
    int m_wait[2];
    int m_stalls[2];

    typedef struct packed {
        logic [4:0] en;   // {if, id, exe, mem, wb}
        logic       idf;
        logic       exf;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       err;
    } exp_t;

    pipe_hazard_unit #(.AW(5), .BR_STAGE(1), .MEM_TO(8), .CW(16)) dut_id (
        .clk(clk), .rst_n(rst_n),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rs_use(id_rs_use), .i_id_rt_use(id_rt_use),
        .i_exe_rs(exe_rs), .i_exe_rt(exe_rt), .i_exe_wdst(exe_wdst), .i_mem_wdst(mem_wdst),
        .i_wb_wdst(wb_wdst), .i_exe_wen(exe_wen), .i_mem_wen(mem_wen), .i_wb_wen(wb_wen),
        .i_exe_is_load(exe_is_load), .i_mem_is_load(mem_is_load),
        .i_id_is_branch(id_is_branch), .i_branch_taken(branch_taken),
        .i_dmem_req(dmem_req), .i_dmem_ack(dmem_ack),
        .o_if_en(if_en[0]), .o_id_en(id_en[0]), .o_exe_en(exe_en[0]), .o_mem_en(mem_en[0]),
        .o_wb_en(wb_en[0]), .o_id_flush(id_flush[0]), .o_exe_flush(exe_flush[0]),
        .o_fwd_a(fwd_a[0]), .o_fwd_b(fwd_b[0]), .o_mem_err(mem_err[0]), .o_stall_cnt(stall_cnt[0])
    );

    pipe_hazard_unit #(.AW(5), .BR_STAGE(2), .MEM_TO(0), .CW(16)) dut_exe (
        .clk(clk), .rst_n(rst_n),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rs_use(id_rs_use), .i_id_rt_use(id_rt_use),
        .i_exe_rs(exe_rs), .i_exe_rt(exe_rt), .i_exe_wdst(exe_wdst), .i_mem_wdst(mem_wdst),
        .i_wb_wdst(wb_wdst), .i_exe_wen(exe_wen), .i_mem_wen(mem_wen), .i_wb_wen(wb_wen),
        .i_exe_is_load(exe_is_load), .i_mem_is_load(mem_is_load),
        .i_id_is_branch(id_is_branch), .i_branch_taken(branch_taken),
        .i_dmem_req(dmem_req), .i_dmem_ack(dmem_ack),
        .o_if_en(if_en[1]), .o_id_en(id_en[1]), .o_exe_en(exe_en[1]), .o_mem_en(mem_en[1]),
        .o_wb_en(wb_en[1]), .o_id_flush(id_flush[1]), .o_exe_flush(exe_flush[1]),
        .o_fwd_a(fwd_a[1]), .o_fwd_b(fwd_b[1]), .o_mem_err(mem_err[1]), .o_stall_cnt(stall_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    // Which source a value for register src would come from
    function automatic logic [1:0] fwd_of(input logic [4:0] src);
        if (src == 0) return 2'd0;
        if (mem_wen && mem_wdst == src && !mem_is_load) return 2'd1;
        if (wb_wen && wb_wdst == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit reads(input logic [4:0] dst);
        return (dst != 0) && ((id_rs_use && id_rs == dst) || (id_rt_use && id_rt == dst));
    endfunction

    // What the outputs must be this cycle for configuration k
    function automatic exp_t expect_of(input int k);
        exp_t e;
        bit   mem_busy, ld_use, br_haz;
        e = '0;
        if (!m_live[k]) return e;
        e.fa = fwd_of(exe_rs);
        e.fb = fwd_of(exe_rt);
        if (m_err[k]) begin
            e.err = 1'b1;
            return e;
        end
        mem_busy = m_busy[k] ? !dmem_ack : (dmem_req && !dmem_ack);
        if (mem_busy) return e;
        e.en   = 5'b11111;
        ld_use = exe_is_load && exe_wen && reads(exe_wdst);
        br_haz = (br_of[k] == 1) && id_is_branch &&
                 ((exe_wen && reads(exe_wdst)) || (mem_is_load && mem_wen && reads(mem_wdst)));
        if (br_of[k] == 2 && branch_taken) begin
            e.idf = 1'b1;
            e.exf = 1'b1;
        end else if (ld_use || br_haz) begin
            e.en  = 5'b00111;
            e.exf = 1'b1;
        end else if (br_of[k] == 1 && branch_taken) begin
            e.idf = 1'b1;
        end
        return e;
    endfunction

    // Every cycle: compare both DUTs to the model, then advance the model past the next edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            if (!rst_n) begin
                m_live[k] = 0; m_busy[k] = 0; m_err[k] = 0; m_wait[k] = 0; m_stalls[k] = 0;
                e = '0;
            end else begin
                e = expect_of(k);
            end
            chk($sformatf("dut%0d enables", k),
                {if_en[k], id_en[k], exe_en[k], mem_en[k], wb_en[k]}, e.en);
            chk($sformatf("dut%0d id_flush", k), id_flush[k], e.idf);
            chk($sformatf("dut%0d exe_flush", k), exe_flush[k], e.exf);
            chk($sformatf("dut%0d fwd_a", k), fwd_a[k], e.fa);
            chk($sformatf("dut%0d fwd_b", k), fwd_b[k], e.fb);
            chk($sformatf("dut%0d mem_err", k), mem_err[k], e.err);
            chk($sformatf("dut%0d stall_cnt", k), stall_cnt[k], m_stalls[k]);
            if (rst_n) begin
                if (m_live[k] && !m_err[k] && !e.en[4] && m_stalls[k] < 65535) m_stalls[k]++;
                if (!m_err[k]) begin
                    if (m_busy[k]) begin
                        if (dmem_ack) m_busy[k] = 0;
                        else begin
                            m_wait[k]++;
                            if (mto_of[k] != 0 && m_wait[k] == mto_of[k]) begin
                                m_err[k]  = 1;
                                m_busy[k] = 0;
                            end
                        end
                    end else if (dmem_req && !dmem_ack) begin
                        m_busy[k] = 1;
                        m_wait[k] = 0;
                    end
                end
                m_live[k] = 1;
            end
        end
    end

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_rs_use = 0; id_rt_use = 0;
        exe_rs = 0; exe_rt = 0; exe_wdst = 0; mem_wdst = 0; wb_wdst = 0;
        exe_wen = 0; mem_wen = 0; wb_wen = 0; exe_is_load = 0; mem_is_load = 0;
        id_is_branch = 0; branch_taken = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base0, base1;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        #1 chk("first cycle after reset if_en", if_en[0], 1);
        tick();

        // Forwarding pins
        tick();
        exe_rs = 3; mem_wdst = 3; mem_wen = 1; wb_wdst = 3; wb_wen = 1;
        #1 chk("fwd_a mem", fwd_a[0], 1);
        tick(); mem_wen = 0;
        #1 chk("fwd_a wb", fwd_a[0], 2);
        tick(); exe_rs = 0; mem_wen = 1;
        #1 chk("fwd_a r0", fwd_a[0], 0);
        tick(); exe_rt = 3; mem_is_load = 1;
        #1 chk("fwd_b mem load falls to wb", fwd_b[1], 2);
        tick(); clear_inputs();

        // Load-use stall
        tick();
        exe_is_load = 1; exe_wen = 1; exe_wdst = 5; id_rt = 5; id_rt_use = 1;
        base0 = stall_cnt[0];
        #1 chk("load-use if_en", if_en[0], 0);
        chk("load-use id_en", id_en[0], 0);
        chk("load-use exe_flush", exe_flush[0], 1);
        tick(); clear_inputs();
        #1 chk("load-use stall_cnt +1", stall_cnt[0] - base0, 1);
        chk("load-use released if_en", if_en[0], 1);

        // Taken branch with simultaneous load-use
        tick();
        exe_is_load = 1; exe_wen = 1; exe_wdst = 5; id_rt = 5; id_rt_use = 1; branch_taken = 1;
        #1 chk("exe-branch id_flush", id_flush[1], 1);
        chk("exe-branch exe_flush", exe_flush[1], 1);
        chk("exe-branch if_en", if_en[1], 1);
        chk("id-branch stall wins if_en", if_en[0], 0);
        chk("id-branch stall no id_flush", id_flush[0], 0);
        tick(); clear_inputs();

        // ID-resolved branch operand hazards
        tick();
        id_is_branch = 1; id_rs = 7; id_rs_use = 1; exe_wdst = 7; exe_wen = 1;
        #1 chk("branch exe-operand stall", if_en[0], 0);
        chk("exe-mode no operand stall", if_en[1], 1);
        tick(); exe_wen = 0; exe_wdst = 0; mem_wdst = 7; mem_wen = 1; mem_is_load = 1;
        #1 chk("branch mem-load stall", if_en[0], 0);
        tick(); clear_inputs(); id_is_branch = 1; branch_taken = 1;
        #1 chk("id-branch taken id_flush", id_flush[0], 1);
        chk("id-branch taken exe_flush", exe_flush[0], 0);
        tick(); clear_inputs();

        // Memory wait with ack after 4 cycles
        tick();
        dmem_req = 1; dmem_ack = 0;
        base0 = stall_cnt[0]; base1 = stall_cnt[1];
        #1 chk("mem req cycle wb_en", wb_en[0], 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            #1 chk("mem wait mem_en", mem_en[0], 0);
        end
        tick(); dmem_ack = 1;
        #1 chk("ack cycle if_en", if_en[0], 1);
        chk("ack cycle wb_en", wb_en[1], 1);
        tick(); dmem_req = 0; dmem_ack = 0;
        #1 chk("mem wait stall_cnt +4", stall_cnt[0] - base0, 4);
        chk("mem wait stall_cnt +4 b", stall_cnt[1] - base1, 4);

        // Ack in the request cycle
        tick(); dmem_req = 1; dmem_ack = 1; base0 = stall_cnt[0];
        #1 chk("same-cycle ack if_en", if_en[0], 1);
        tick(); dmem_req = 0; dmem_ack = 0;
        #1 chk("same-cycle ack no stall", stall_cnt[0] - base0, 0);

        // Timeout into ERR
        tick(); dmem_req = 1; base0 = stall_cnt[0];
        for (int i = 1; i < 12; i++) tick();
        #1 chk("timeout mem_err", mem_err[0], 1);
        chk("timeout stall cycles", stall_cnt[0] - base0, 9);
        chk("no-timeout mem_err", mem_err[1], 0);
        chk("no-timeout still waiting", if_en[1], 0);
        tick(); dmem_ack = 1;
        #1 chk("err ignores ack", if_en[0], 0);
        chk("no-timeout ack releases", if_en[1], 1);
        tick(); dmem_req = 0; dmem_ack = 0;
        #1 chk("mem_err held", mem_err[0], 1);
        tick(); rst_n = 1'b0;
        #1 chk("reset clears mem_err now", mem_err[0], 0);
        chk("reset clears stall_cnt now", stall_cnt[0], 0);
        tick(); tick(); rst_n = 1'b1;

        // Reset mid-wait, then a stale ack
        tick(); tick(); dmem_req = 1;
        tick(); tick(); rst_n = 1'b0; dmem_req = 0;
        tick(); dmem_ack = 1;
        tick(); rst_n = 1'b1;
        tick();
        #1 chk("post mid-wait reset if_en", if_en[0], 1);
        chk("post mid-wait reset mem_err", mem_err[0], 0);
        tick(); clear_inputs();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
